// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: field bundle in, encoded word plus word address out.
// Ports: clk/rst_n; base_load/base_addr address counter load; in_valid/in_ready
// and fmt/opcode/rd/rs1/rs2/funct3/funct7/imm bundle; out_valid/out_ready,
// out_instr/out_addr; word_count; sticky err_illegal, wrapped.
// Optional macro RANGE_CHECK_EN adds the immediate range check and err_range.
module rv32i_instr_encoder #(
  parameter int size   = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [size-1:0]   imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [size-1:0]   out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              wrapped
`ifdef RANGE_CHECK_EN
  ,
  output logic              err_range
`endif
);

  localparam logic [ADDR_W-1:0] ONE = 1;

  logic is_i, is_s, is_b, is_u, is_j, is_r;
  logic illegal, range_bad, drop;
  logic accept, take, handoff;
  logic [size-1:0]   enc;
  logic [ADDR_W-1:0] cnt, cur_addr;

  assign is_i = (fmt == 3'd0);
  assign is_s = (fmt == 3'd1);
  assign is_b = (fmt == 3'd2);
  assign is_u = (fmt == 3'd3);
  assign is_j = (fmt == 3'd4);
  assign is_r = (fmt == 3'd5);
  assign illegal = (fmt > 3'd5);

  always_comb begin
    enc = '0;
    unique case (1'b1)
      is_r: enc = {funct7, rs2, rs1,
                   funct3, rd, opcode};
      is_i: enc = {imm[11:0], rs1,
                   funct3, rd, opcode};
      is_s: enc = {imm[11:5], rs2, rs1,
                   funct3, imm[4:0], opcode};
      is_b: enc = {imm[12], imm[10:5],
                   rs2, rs1, funct3,
                   imm[4:1], imm[11], opcode};
      is_u: enc = {imm[31:12], rd, opcode};
      is_j: enc = {imm[20], imm[10:1],
                   imm[11], imm[19:12],
                   rd, opcode};
      default: enc = '0;
    endcase
  end

`ifdef RANGE_CHECK_EN
  // Upper bits must be a pure sign extension of the field's top bit.
  always_comb begin
    range_bad = 1'b0;
    unique case (1'b1)
      is_i, is_s:
        range_bad = imm[31:11] != {21{imm[11]}};
      is_b:
        range_bad = (imm[31:12] != {20{imm[12]}})
                  | imm[0];
      is_j:
        range_bad = (imm[31:20] != {12{imm[20]}})
                  | imm[0];
      default: range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign drop     = illegal | range_bad;
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign take     = accept & ~drop;
  assign handoff  = out_valid & out_ready;
  // A coincident base_load applies to the word being accepted.
  assign cur_addr = base_load ? base_addr : cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_addr    <= '0;
      cnt         <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
      wrapped     <= 1'b0;
    end else begin
      if (take) begin
        out_valid <= 1'b1;
        out_instr <= enc;
        out_addr  <= cur_addr;
        cnt       <= cur_addr + ONE;
      end else begin
        if (handoff)
          out_valid <= 1'b0;
        if (base_load)
          cnt <= base_addr;
      end
      word_count <= (base_load ? '0 : word_count)
                  + {{ADDR_W{1'b0}}, handoff};
      wrapped <= (base_load ? 1'b0 : wrapped)
               | (take & (&cur_addr));
      if (accept & illegal)
        err_illegal <= 1'b1;
    end
  end

`ifdef RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_range <= 1'b0;
    else if (accept & ~illegal & range_bad)
      err_range <= 1'b1;
  end
`endif

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
Assembles 32-bit RV32I instruction words from decoded field bundles (format, opcode, registers, funct fields, immediate). It is the inverse of the pipeline's instruction decoder. Used by the boot/debug loader path to stream encoded words, each tagged with an auto-incrementing word address, into instruction memory. It has a valid/ready input, a one-stage registered encode, and a valid/ready output with backpressure and error flags.

Parameters:
size, 32, instruction width; only 32 is supported.
ADDR_W, 10, instruction-memory word-address width.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  synchronous, active-low reset.
base_load  input  1  load base_addr into the address counter.
base_addr  input  ADDR_W  start word address.
in_valid  input  1  field bundle valid.
in_ready  output  1  encoder can accept a bundle.
fmt  input  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=R; 6 and 7 are illegal.
opcode  input  7  passed to bits [6:0].
rd  input  5  destination register.
rs1  input  5  source register 1.
rs2  input  5  source register 2.
funct3  input  3  function field.
funct7  input  7  R-type only.
imm  input  size  immediate, sign-extended byte offset for I/S/B/J; for U the upper 20 bits are used.
out_valid  output  1  encoded word valid.
out_ready  input  1  sink accepts the word.
out_instr  output  size  encoded instruction.
out_addr  output  ADDR_W  word address of out_instr.
word_count  output  ADDR_W+1  number of words accepted by the sink since reset or base_load.
err_illegal  output  1  sticky: an illegal fmt was seen.
wrapped  output  1  sticky: the address counter wrapped.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears: out_valid=0, out_instr=0, out_addr=0, address counter=0, word_count=0, err_illegal=0, wrapped=0.
- Reset mid-transfer discards any held word with no partial output.
- in_ready = ~out_valid | out_ready (combinational).
- Accept occurs when in_valid & in_ready. Full throughput: one word per cycle with no bubbles.
- Latency is 1 cycle: fields accepted at edge N appear on out_instr at edge N+1 with out_valid=1.
- While out_valid & ~out_ready, out_instr and out_addr hold stable and no bundle is accepted.
- Encoding, MSB to LSB:
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - U: imm[31:12] | rd | opcode.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
- Unused fields are ignored. Out-of-range immediate bits are silently truncated unless the optional feature below is compiled in.
- Illegal fmt:
  - The bundle is accepted (in_ready behaves normally) and dropped: no output word, no address advance.
  - err_illegal is set and stays set until reset.
- Address counter:
  - out_addr takes the counter value at accept.
  - The counter increments on each non-dropped accept and wraps from 2^ADDR_W-1 to 0.
  - wrapped is set on the wrap and stays set.
- word_count increments on each out_valid & out_ready.
- base_load:
  - Sets counter=base_addr and word_count=0 and clears wrapped.
  - When base_load coincides with an accept, the accepted word takes base_addr and the counter becomes base_addr+1.
  - A word already held on the output keeps its address.
- Simultaneous output handoff and new accept: the new word replaces the old one in the same edge and out_valid stays 1.

Optional Feature:
RANGE_CHECK_EN:
- Defined: before encoding, imm is checked against its format's range.
  - I and S: signed 12-bit.
  - B: signed 13-bit, and imm[0] must be 0.
  - J: signed 21-bit, and imm[0] must be 0.
  - U and R: not checked.
- A violation drops the bundle exactly like an illegal fmt and sets a sticky output err_range (1 bit, reset 0). The err_range port exists only when the macro is defined.
- Undefined: no check; out-of-range bits are truncated, odd B/J offsets lose bit 0, and there is no err_range port.

Test Plan:
- Reset, then base_load base_addr=0x010. Send I: opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 (ADDI x1,x0,5) -> next cycle out_instr=0x00500093, out_addr=0x010.
- Back-to-back with out_ready=1:
  - S: opcode=0x23, rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423.
  - B: opcode=0x63, rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3.
  - U: opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
  - J: opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF.
  - R: opcode=0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> 0x002081B3.
  - Check the addresses increment by 1 and word_count=6.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and out_instr/out_addr are stable. Release -> no word is lost or duplicated.
- Send fmt=6 between two ADDIs -> err_illegal=1, and the ADDIs land at consecutive addresses.
- base_addr=2^ADDR_W-1, send 2 words -> addresses 0x3FF then 0x000, wrapped=1.
- Assert rst_n=0 while out_valid=1 with out_ready=0 -> next cycle all outputs are 0. With RANGE_CHECK_EN: I imm=2048 -> dropped, err_range=1.
